// File: rtl/l2_cache_control_if.sv
// ---------------------------------------------------------------------------
// l2_cache_control_if
//   Bundle of every non-clock signal around the L2 control FSM.
//   - L1 line port   : mem_read, mem_write, mem_address -> mem_resp
//   - pmem port      : pmem_read, pmem_write, pmem_address <- pmem_resp
//   - array port     : read/write index, load strobes and write data out;
//                      registered tag/valid/dirty/LRU outputs back in.
//   modport master : the controller's view (drives pmem and array controls).
//   modport slave  : the environment's view (L1 requester, pmem, arrays).
// ---------------------------------------------------------------------------
interface l2_cache_control_if #(
  parameter int s_index  = 3,
  parameter int s_offset = 5,
  parameter int s_tag    = 32 - s_offset - s_index
);
  // L1 side
  logic               mem_read;
  logic               mem_write;
  logic [31:0]        mem_address;
  logic               mem_resp;
  // pmem side
  logic               pmem_read;
  logic               pmem_write;
  logic [31:0]        pmem_address;
  logic               pmem_resp;
  // array side
  logic [s_index-1:0] arr_rindex;
  logic [s_index-1:0] arr_windex;
  logic [s_tag-1:0]   tag_out0, tag_out1;
  logic               valid_out0, valid_out1;
  logic               dirty_out0, dirty_out1;
  logic               lru_out;
  logic [s_tag-1:0]   tag_in;
  logic               tag_load0, tag_load1;
  logic               valid_load0, valid_load1;
  logic               dirty_load0, dirty_load1;
  logic               data_load0, data_load1;
  logic               lru_load;
  logic               dirty_in;
  logic               lru_in;
  logic               data_sel;
  logic               wb_way;

  modport master (
    input  mem_read, mem_write, mem_address, pmem_resp,
           tag_out0, tag_out1, valid_out0, valid_out1,
           dirty_out0, dirty_out1, lru_out,
    output mem_resp, pmem_read, pmem_write, pmem_address,
           arr_rindex, arr_windex, tag_in,
           tag_load0, tag_load1, valid_load0, valid_load1,
           dirty_load0, dirty_load1, data_load0, data_load1,
           lru_load, dirty_in, lru_in, data_sel, wb_way
  );

  modport slave (
    output mem_read, mem_write, mem_address, pmem_resp,
           tag_out0, tag_out1, valid_out0, valid_out1,
           dirty_out0, dirty_out1, lru_out,
    input  mem_resp, pmem_read, pmem_write, pmem_address,
           arr_rindex, arr_windex, tag_in,
           tag_load0, tag_load1, valid_load0, valid_load1,
           dirty_load0, dirty_load1, data_load0, data_load1,
           lru_load, dirty_in, lru_in, data_sel, wb_way
  );
endinterface

// File: rtl/l2_cache_control.sv
// ---------------------------------------------------------------------------
// l2_cache_control
//   Control FSM of the 2-way set-associative L2 cache (256-bit lines).
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : l2_cache_control_if.master
//              L1 request in / mem_resp out, pmem request out / pmem_resp in,
//              array indices, load strobes and write data out, registered
//              array outputs in (1-cycle read latency, write-to-read bypass).
//   States: IDLE -> COMPARE -> (hit) IDLE
//                           -> (miss, dirty victim) WRITEBACK -> FILL
//                           -> (miss, clean victim) FILL
//           FILL -> COMPARE (re-compare hits thanks to the array bypass and
//           performs the LRU update and any write merge).
// ---------------------------------------------------------------------------
module l2_cache_control #(
  parameter int s_index  = 3,
  parameter int s_offset = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  l2_cache_control_if.master bus
);
  localparam int s_tag = 32 - s_offset - s_index;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

  typedef struct packed {
    logic [s_tag-1:0]   tag;
    logic [s_index-1:0] idx;
    logic               wr;
  } req_t;

  state_t           state, state_nx;
  req_t             req;
  logic             victim;
  logic [s_tag-1:0] vtag;

  logic hit0, hit1, hit, hit_way, vic_dirty;

  // Offset bits never matter to a line-granular controller.
  logic unused_offset;
  assign unused_offset = ^bus.mem_address[s_offset-1:0];

  // Way 0 wins if both ways ever hit (illegal array state).
  assign hit0      = bus.valid_out0 && (bus.tag_out0 == req.tag);
  assign hit1      = bus.valid_out1 && (bus.tag_out1 == req.tag);
  assign hit       = hit0 || hit1;
  assign hit_way   = ~hit0;
  assign vic_dirty = bus.lru_out ? (bus.valid_out1 && bus.dirty_out1)
                                 : (bus.valid_out0 && bus.dirty_out0);

  assign bus.arr_windex = req.idx;
  assign bus.tag_in     = req.tag;

  // -------------------------------------------------------------------------
  // State and request/victim registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      req    <= '0;
      victim <= 1'b0;
      vtag   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (bus.mem_read || bus.mem_write)) begin
        req.tag <= bus.mem_address[31 -: s_tag];
        req.idx <= bus.mem_address[s_offset +: s_index];
        req.wr  <= bus.mem_write;  // write wins when both are high
      end
      // Victim way and its tag are frozen on the way out of COMPARE so the
      // writeback address cannot move even if the arrays were to change.
      if (state == COMPARE && !hit) begin
        victim <= bus.lru_out;
        vtag   <= bus.lru_out ? bus.tag_out1 : bus.tag_out0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next state and outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx         = state;
    bus.mem_resp     = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.arr_rindex   = req.idx;
    bus.tag_load0    = 1'b0;
    bus.tag_load1    = 1'b0;
    bus.valid_load0  = 1'b0;
    bus.valid_load1  = 1'b0;
    bus.dirty_load0  = 1'b0;
    bus.dirty_load1  = 1'b0;
    bus.data_load0   = 1'b0;
    bus.data_load1   = 1'b0;
    bus.lru_load     = 1'b0;
    bus.dirty_in     = 1'b0;
    bus.lru_in       = 1'b0;
    bus.data_sel     = 1'b0;
    bus.wb_way       = 1'b0;

    case (state)
      IDLE: begin
        // Read the set of the incoming request so COMPARE sees it next cycle.
        bus.arr_rindex = bus.mem_address[s_offset +: s_index];
        if (bus.mem_read || bus.mem_write) state_nx = COMPARE;
      end

      COMPARE: begin
        if (hit) begin
          bus.mem_resp = 1'b1;
          bus.lru_load = 1'b1;
          bus.lru_in   = ~hit_way;
          if (req.wr) begin
            bus.data_load0  = ~hit_way;
            bus.data_load1  = hit_way;
            bus.dirty_load0 = ~hit_way;
            bus.dirty_load1 = hit_way;
            bus.dirty_in    = 1'b1;
            bus.data_sel    = 1'b0;
          end
          state_nx = IDLE;
        end else if (vic_dirty) begin
          state_nx = WRITEBACK;
        end else begin
          state_nx = FILL;
        end
      end

      WRITEBACK: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {vtag, req.idx, {s_offset{1'b0}}};
        bus.wb_way       = victim;
        if (bus.pmem_resp) state_nx = FILL;
      end

      FILL: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {req.tag, req.idx, {s_offset{1'b0}}};
        if (bus.pmem_resp) begin
          bus.data_load0  = ~victim;
          bus.data_load1  = victim;
          bus.tag_load0   = ~victim;
          bus.tag_load1   = victim;
          bus.valid_load0 = ~victim;
          bus.valid_load1 = victim;
          bus.dirty_load0 = ~victim;
          bus.dirty_load1 = victim;
          bus.dirty_in    = 1'b0;
          bus.data_sel    = 1'b1;
          state_nx        = COMPARE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_l2_cache_control.sv
module tb_l2_cache_control;
  localparam int SI = 3;
  localparam int SO = 5;
  localparam int ST = 32 - SO - SI;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l2_cache_control_if #(.s_index(SI), .s_offset(SO)) bus();
  l2_cache_control #(.s_index(SI), .s_offset(SO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- array model: registered outputs with write bypass -----
  logic [ST-1:0] ta [2][8];
  logic          va [2][8];
  logic          da [2][8];
  logic          la [8];
  logic          clr = 1'b1;
  wire           byp = (bus.arr_windex == bus.arr_rindex);

  always @(posedge clk) begin
    if (clr) begin
      for (int s = 0; s < 8; s++) begin
        ta[0][s] <= '0; ta[1][s] <= '0;
        va[0][s] <= 1'b0; va[1][s] <= 1'b0;
        da[0][s] <= 1'b0; da[1][s] <= 1'b0;
        la[s] <= 1'b0;
      end
      bus.tag_out0 <= '0; bus.tag_out1 <= '0;
      bus.valid_out0 <= 1'b0; bus.valid_out1 <= 1'b0;
      bus.dirty_out0 <= 1'b0; bus.dirty_out1 <= 1'b0;
      bus.lru_out <= 1'b0;
    end else begin
      if (bus.tag_load0)   ta[0][bus.arr_windex] <= bus.tag_in;
      if (bus.tag_load1)   ta[1][bus.arr_windex] <= bus.tag_in;
      if (bus.valid_load0) va[0][bus.arr_windex] <= 1'b1;
      if (bus.valid_load1) va[1][bus.arr_windex] <= 1'b1;
      if (bus.dirty_load0) da[0][bus.arr_windex] <= bus.dirty_in;
      if (bus.dirty_load1) da[1][bus.arr_windex] <= bus.dirty_in;
      if (bus.lru_load)    la[bus.arr_windex]    <= bus.lru_in;
      bus.tag_out0   <= (bus.tag_load0 && byp)   ? bus.tag_in   : ta[0][bus.arr_rindex];
      bus.tag_out1   <= (bus.tag_load1 && byp)   ? bus.tag_in   : ta[1][bus.arr_rindex];
      bus.valid_out0 <= (bus.valid_load0 && byp) ? 1'b1         : va[0][bus.arr_rindex];
      bus.valid_out1 <= (bus.valid_load1 && byp) ? 1'b1         : va[1][bus.arr_rindex];
      bus.dirty_out0 <= (bus.dirty_load0 && byp) ? bus.dirty_in : da[0][bus.arr_rindex];
      bus.dirty_out1 <= (bus.dirty_load1 && byp) ? bus.dirty_in : da[1][bus.arr_rindex];
      bus.lru_out    <= (bus.lru_load && byp)    ? bus.lru_in   : la[bus.arr_rindex];
    end
  end

  // ---------------- pmem model: responds after pw_cfg wait cycles ---------
  int  pw_cfg = 0;
  int  pcnt;
  wire pact = bus.pmem_read | bus.pmem_write;
  assign bus.pmem_resp = pact && (pcnt == pw_cfg);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        pcnt <= 0;
    else if (!pact || bus.pmem_resp)   pcnt <= 0;
    else                               pcnt <= pcnt + 1;
  end

  // ---------------- reference cache model --------------------------------
  logic          mv [2][8];
  logic          md [2][8];
  logic [ST-1:0] mt [2][8];
  logic          ml [8];

  typedef struct {
    logic          rd, wr;
    logic [2:0]    idx;
    logic [ST-1:0] tag;
    int            pw;
    int            lat;      // negedges from request drive to mem_resp
    logic          wb;
    logic [31:0]   wb_addr;
    logic          fill;
    logic          way;      // hit way, or victim way on a miss
    logic [1:0]    dl;       // data/dirty load strobes on the responding hit
    logic          di;
  } vec_t;

  typedef struct {
    logic          wr;
    logic [31:0]   addr;
    logic          wbw;
    logic [1:0]    tl, vl, dyl, dal;
    logic          ds, di;
    logic [ST-1:0] ti;
  } pm_t;

  function automatic vec_t mk(logic rd, logic wr, logic [2:0] idx, logic [ST-1:0] tag,
                              int pw, int lat, logic wb, logic [31:0] wb_addr,
                              logic fill, logic way, logic [1:0] dl, logic di);
    vec_t v;
    v.rd = rd; v.wr = wr; v.idx = idx; v.tag = tag; v.pw = pw; v.lat = lat;
    v.wb = wb; v.wb_addr = wb_addr; v.fill = fill; v.way = way; v.dl = dl; v.di = di;
    return v;
  endfunction

  // Cache semantics: LRU victim, write-back on dirty eviction, write-allocate.
  task automatic predict(inout vec_t v);
    logic h0, h1, hit, w;
    h0  = mv[0][v.idx] && (mt[0][v.idx] == v.tag);
    h1  = mv[1][v.idx] && (mt[1][v.idx] == v.tag);
    hit = h0 || h1;
    w   = h0 ? 1'b0 : (h1 ? 1'b1 : ml[v.idx]);
    v.way     = w;
    v.fill    = !hit;
    v.wb      = !hit && mv[w][v.idx] && md[w][v.idx];
    v.wb_addr = {mt[w][v.idx], v.idx, 5'b0};
    v.lat     = hit ? 1 : ((v.wb ? v.pw + 1 : 0) + v.pw + 3);
    v.dl      = v.wr ? (w ? 2'b10 : 2'b01) : 2'b00;
    v.di      = v.wr;
    if (!hit) begin
      mv[w][v.idx] = 1'b1; mt[w][v.idx] = v.tag; md[w][v.idx] = 1'b0;
    end
    ml[v.idx] = !w;
    if (v.wr) md[w][v.idx] = 1'b1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {bus.tag_load0, bus.tag_load1, bus.valid_load0, bus.valid_load1,
            bus.dirty_load0, bus.dirty_load1, bus.data_load0, bus.data_load1,
            bus.lru_load, bus.mem_resp, bus.pmem_read, bus.pmem_write,
            bus.dirty_in, bus.lru_in, bus.data_sel, bus.wb_way};
  endfunction

  // Called at a negedge with the FSM in IDLE; returns at a negedge in IDLE.
  task automatic do_req(vec_t e);
    pm_t         log[$];
    pm_t         p;
    int          cyc, viol;
    bit          got, pprev, wprev;
    logic [31:0] aprev;
    logic [1:0]  s_dl, s_dyl;
    logic        s_di, s_li, s_ll, s_ds;
    pw_cfg = e.pw;
    bus.mem_read    = e.rd;
    bus.mem_write   = e.wr;
    bus.mem_address = {e.tag, e.idx, 5'($urandom_range(0, 31))};
    cyc = 0; viol = 0; got = 0; pprev = 0; wprev = 0; aprev = '0;
    s_dl = '0; s_dyl = '0; s_di = 0; s_li = 0; s_ll = 0; s_ds = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.pmem_read && bus.pmem_write) viol++;
      if (pact && pprev && (bus.pmem_write == wprev) && (bus.pmem_address != aprev)) viol++;
      pprev = pact; wprev = bus.pmem_write; aprev = bus.pmem_address;
      if (bus.pmem_resp) begin
        p.wr = bus.pmem_write; p.addr = bus.pmem_address; p.wbw = bus.wb_way;
        p.tl = {bus.tag_load1, bus.tag_load0};   p.vl  = {bus.valid_load1, bus.valid_load0};
        p.dyl = {bus.dirty_load1, bus.dirty_load0}; p.dal = {bus.data_load1, bus.data_load0};
        p.ds = bus.data_sel; p.di = bus.dirty_in; p.ti = bus.tag_in;
        log.push_back(p);
      end
      if (bus.mem_resp) begin
        got = 1;
        s_dl = {bus.data_load1, bus.data_load0}; s_dyl = {bus.dirty_load1, bus.dirty_load0};
        s_di = bus.dirty_in; s_li = bus.lru_in; s_ll = bus.lru_load; s_ds = bus.data_sel;
      end
    end
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    chk("resp_seen", got, 1);
    chk("latency", cyc, e.lat);
    if (got) begin
      chk("hit_lru_in", s_li, !e.way);
      chk("hit_lru_load", s_ll, 1);
      chk("hit_data_load", s_dl, e.dl);
      chk("hit_dirty_load", s_dyl, e.dl);
      chk("hit_dirty_in", s_di, e.di);
      chk("hit_data_sel", s_ds, 0);
    end
    chk("pmem_count", log.size(), e.wb + e.fill);
    if (e.wb && log.size() > 0) begin
      chk("wb_is_write", log[0].wr, 1);
      chk("wb_addr", log[0].addr, e.wb_addr);
      chk("wb_way", log[0].wbw, e.way);
    end
    if (e.fill && log.size() > 0) begin
      p = log[log.size()-1];
      chk("fill_is_read", p.wr, 0);
      chk("fill_addr", p.addr, {e.tag, e.idx, 5'b0});
      chk("fill_tag_load", p.tl, e.way ? 2'b10 : 2'b01);
      chk("fill_valid_load", p.vl, e.way ? 2'b10 : 2'b01);
      chk("fill_dirty_load", p.dyl, e.way ? 2'b10 : 2'b01);
      chk("fill_data_load", p.dal, e.way ? 2'b10 : 2'b01);
      chk("fill_data_sel", p.ds, 1);
      chk("fill_dirty_in", p.di, 0);
      chk("fill_tag_in", p.ti, e.tag);
    end
    chk("pmem_protocol", viol, 0);
    @(negedge clk);
    chk("resp_single_pulse", bus.mem_resp, 0);
    for (int w = 0; w < 2; w++) begin
      chk("arr_valid", va[w][e.idx], mv[w][e.idx]);
      chk("arr_dirty", da[w][e.idx], md[w][e.idx]);
      if (mv[w][e.idx]) chk("arr_tag", ta[w][e.idx], mt[w][e.idx]);
    end
    chk("arr_lru", la[e.idx], ml[e.idx]);
  endtask

  vec_t tbl[7];

  initial begin
    vec_t v;
    bit   seen;
    int   op;
    for (int s = 0; s < 8; s++) begin
      mv[0][s] = 0; mv[1][s] = 0; md[0][s] = 0; md[1][s] = 0;
      mt[0][s] = '0; mt[1][s] = '0; ml[s] = 0;
    end
    //            rd wr idx tag        pw lat wb wb_addr       fill way dl     di
    tbl[0] = mk(1, 0, 2, 24'h001234, 3, 6, 0, 32'h0,        1, 0, 2'b00, 0);
    tbl[1] = mk(1, 0, 2, 24'h001234, 0, 1, 0, 32'h0,        0, 0, 2'b00, 0);
    tbl[2] = mk(0, 1, 2, 24'h000AAA, 1, 4, 0, 32'h0,        1, 1, 2'b10, 1);
    tbl[3] = mk(0, 1, 2, 24'h000AAA, 0, 1, 0, 32'h0,        0, 1, 2'b10, 1);
    tbl[4] = mk(1, 0, 2, 24'h001234, 0, 1, 0, 32'h0,        0, 0, 2'b00, 0);
    tbl[5] = mk(1, 0, 2, 24'h005555, 2, 8, 1, 32'h000AAA40, 1, 1, 2'b00, 0);
    tbl[6] = mk(1, 1, 5, 24'h00BEEF, 1, 4, 0, 32'h0,        1, 0, 2'b01, 1);

    // Reset state
    bus.mem_read = 0; bus.mem_write = 0;
    bus.mem_address = {24'h0, 3'd3, 5'd0};
    repeat (3) @(negedge clk);
    chk("rst_outputs", outs(), 0);
    chk("rst_pmem_address", bus.pmem_address, 0);
    chk("rst_rindex_follows", bus.arr_rindex, 3);
    chk("rst_windex", bus.arr_windex, 0);
    bus.mem_address = {24'h0, 3'd6, 5'd0};
    #1;
    chk("rst_rindex_comb", bus.arr_rindex, 6);
    clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      v = tbl[i];
      predict(v);      // keep the reference model in step
      do_req(tbl[i]);
    end

    // Reset during FILL wait
    pw_cfg = 5;
    bus.mem_read = 1'b1;
    bus.mem_address = {24'h000777, 3'd6, 5'd0};
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.pmem_read) seen = 1;
    end
    chk("rst_fill_reached", seen, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_fill_outputs", outs(), 0);
    chk("rst_mid_fill_windex", bus.arr_windex, 0);
    bus.mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_no_load_w0", va[0][6], 0);
    chk("rst_no_load_w1", va[1][6], 0);
    v = mk(1, 0, 6, 24'h000777, 0, 0, 0, 0, 0, 0, 0, 0);
    predict(v);
    chk("rst_then_cold_miss", v.fill, 1);
    do_req(v);

    // Randomized requests against the reference model
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 2);
      v = mk(op != 1, op != 0, 3'($urandom_range(0, 2)), 24'h000100 + 24'($urandom_range(0, 3)),
             $urandom_range(0, 3), 0, 0, 0, 0, 0, 0, 0);
      predict(v);
      do_req(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
